spi_ram_responder: RTL and testbench

- Clocked SPI SRAM responder: the target end of the SPI link driven by the team's SPI RAM controller.
- Implements READ (0x03) and WRITE (0x02) sequential-mode commands with ADDR_BITS address bits, backed by an internal byte array.
- Used as the on-chip/bench memory model behind the CPU's SPI pins, so multi-byte controller transfers stream naturally.
- Samples the SPI pins in the clk domain through synchronizers; the SPI clock must be at most clk/4.

---
 rtl/spi_ram_responder.sv | 186 ++++++++++++++++++
 tb/tb_spi_ram_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_responder.sv
// SPI mode-0 SRAM target: READ 0x03 / WRITE 0x02, sequential mode, backed by a byte array.
// Pins are 2-flop synchronized; first read bit is driven <=3 clk after the first post-address fall.
module spi_ram_responder #(
  parameter int ADDR_BITS = 16,
  parameter int MEM_BYTES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk,
  input  logic spi_select,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy,
  output logic cmd_error
);
  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam int CNT_W = $clog2(ADDR_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE
  } state_t;

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_sel_s1, r_sel_s2;
  logic r_mosi_s1, r_mosi_s2;

  state_t                 r_state;
  logic                   r_busy, r_miso, r_cmd_error;
  logic [CNT_W-1:0]       r_cnt;
  logic [7:0]             r_sh;
  logic [7:0]             r_tx;
  logic [ADDR_BITS-1:0]   r_addr_sh;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_rd_flag;
  logic                   r_load;
  logic                   r_wr_en;
  logic [IDX_W-1:0]       r_wr_idx;
  logic [7:0]             r_wr_dat;
  logic [7:0]             r_mem [MEM_BYTES];

  logic                   w_rise, w_fall, w_desel;
  logic [7:0]             w_byte_nxt;
  logic [ADDR_BITS-1:0]   w_addr_nxt;
  logic [IDX_W-1:0]       w_idx;

  assign w_rise     = r_sclk_s2 & ~r_sclk_d;
  assign w_fall     = ~r_sclk_s2 & r_sclk_d;
  assign w_desel    = r_sel_s2;
  assign w_byte_nxt = {r_sh[6:0], r_mosi_s2};
  assign w_addr_nxt = {r_addr_sh[ADDR_BITS-2:0], r_mosi_s2};
  assign w_idx      = r_addr[IDX_W-1:0];

  assign spi_miso  = r_miso;
  assign busy      = r_busy;
  assign cmd_error = r_cmd_error;

  // Select resets to the deasserted level so a held-low select after reset reads as a new command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_sel_s1  <= 1'b1;
      r_sel_s2  <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_sel_s1  <= spi_select;
      r_sel_s2  <= r_sel_s1;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_wr_en) r_mem[r_wr_idx] <= r_wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_miso      <= 1'b0;
      r_cmd_error <= 1'b0;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_tx        <= '0;
      r_addr_sh   <= '0;
      r_addr      <= '0;
      r_rd_flag   <= 1'b0;
      r_load      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_dat    <= '0;
    end else begin
      r_cmd_error <= 1'b0;
      r_wr_en     <= 1'b0;
      // Deselect wins over any SPI edge seen in the same cycle; a partial write byte just evaporates.
      if (w_desel) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_miso    <= 1'b0;
        r_cnt     <= '0;
        r_sh      <= '0;
        r_tx      <= '0;
        r_addr_sh <= '0;
        r_addr    <= '0;
        r_rd_flag <= 1'b0;
        r_load    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_CMD;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
          S_CMD: if (w_rise) begin
            r_sh <= w_byte_nxt;
            if (r_cnt == LAST_BIT) begin
              r_cnt <= '0;
              case (w_byte_nxt)
                8'h03: begin r_state <= S_ADDR; r_rd_flag <= 1'b1; end
                8'h02: begin r_state <= S_ADDR; r_rd_flag <= 1'b0; end
                default: begin r_state <= S_IGNORE; r_cmd_error <= 1'b1; end
              endcase
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_ADDR: if (w_rise) begin
            r_addr_sh <= w_addr_nxt;
            if (r_cnt == LAST_ADDR) begin
              r_cnt  <= '0;
              r_addr <= w_addr_nxt;
              r_sh   <= '0;
              if (r_rd_flag) begin
                r_state <= S_READ;
                r_load  <= 1'b1;
              end else begin
                r_state <= S_WRITE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_READ: begin
            // A load never coincides with a fall while SPI clock is at most clk/4.
            if (r_load) begin
              r_tx   <= r_mem[w_idx];
              r_load <= 1'b0;
            end else if (w_fall) begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
              if (r_cnt == LAST_BIT) begin
                r_cnt  <= '0;
                r_addr <= r_addr + 1'b1;
                r_load <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          S_WRITE: if (w_rise) begin
            r_sh <= w_byte_nxt;
            if (r_cnt == LAST_BIT) begin
              r_cnt    <= '0;
              r_wr_en  <= 1'b1;
              r_wr_idx <= w_idx;
              r_wr_dat <= w_byte_nxt;
              r_addr   <= r_addr + 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_IGNORE: r_miso <= 1'b0;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed + randomized bench for spi_ram_responder; an SPI initiator drives the pins,
// and read data is compared against a byte-array model of the memory.
module tb_spi_ram_responder;
  localparam int MEM = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_clk = 1'b0;
  logic spi_select = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, busy, cmd_error;

  int n_cmp = 0;
  int n_bad = 0;
  int half = 4;
  int err_pulses = 0;
  int miso_hi_cycles = 0;
  logic [7:0] model [MEM];
  logic [7:0] rxq [$];

  always #5 clk = ~clk;

  spi_ram_responder #(.ADDR_BITS(16), .MEM_BYTES(MEM)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_select(spi_select),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy), .cmd_error(cmd_error)
  );

  always @(negedge clk) begin
    if (cmd_error === 1'b1) err_pulses++;
    if (spi_miso === 1'b1) miso_hi_cycles++;
  end

  function automatic int idx(input int a);
    return (a & 32'hFFFF) % MEM;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // At clk/4 the synchronizer round trip exceeds half a period, so the initiator samples late in the high phase.
  task automatic shift(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = tx[i];
      repeat (half) @(negedge clk);
      if (half >= 3) rx[i] = spi_miso;
      spi_clk = 1'b1;
      repeat (half) @(negedge clk);
      if (half < 3) rx[i] = spi_miso;
      spi_clk = 1'b0;
    end
  endtask

  task automatic sel_low();
    spi_select = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic sel_high();
    repeat (half) @(negedge clk);
    spi_select = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_after_deselect", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic head(input logic [7:0] cmd, input logic [15:0] addr);
    logic [7:0] rx;
    shift(cmd, 8, rx);
    shift(addr[15:8], 8, rx);
    shift(addr[7:0], 8, rx);
    check("busy_while_selected", 32'(busy), 32'd1);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] d [$]);
    logic [7:0] rx;
    sel_low();
    head(8'h02, addr);
    for (int i = 0; i < d.size(); i++) begin
      shift(d[i], 8, rx);
      model[idx(int'(addr) + i)] = d[i];
    end
    sel_high();
  endtask

  task automatic do_read(input logic [15:0] addr, input int n);
    logic [7:0] rx;
    sel_low();
    head(8'h03, addr);
    rxq.delete();
    for (int i = 0; i < n; i++) begin
      shift(8'($urandom), 8, rx);
      rxq.push_back(rx);
      check($sformatf("read@%04h+%0d", addr, i), 32'(rx), 32'(model[idx(int'(addr) + i)]));
    end
    sel_high();
  endtask

  initial begin
    logic [7:0] wq [$];
    logic [7:0] rx;
    logic [15:0] a;
    int e0, m0, n;

    repeat (3) @(negedge clk);
    check("reset_miso", 32'(spi_miso), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cmd_error", 32'(cmd_error), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Fill the whole store so every later read has a known expectation.
    half = 2;
    wq.delete();
    for (int i = 0; i < MEM; i++) wq.push_back(8'($urandom));
    do_write(16'h0000, wq);
    half = 4;

    for (int t = 0; t < 16; t++) begin
      a = 16'($urandom_range(0, 65535));
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        do_write(a, wq);
      end else begin
        do_read(a, n);
      end
    end

    e0 = err_pulses;
    wq.delete(); wq.push_back(8'hBE); wq.push_back(8'hEF);
    do_write(16'h0010, wq);
    do_read(16'h0010, 2);
    check("wr_rd_byte0", 32'(rxq[0]), 32'hBE);
    check("wr_rd_byte1", 32'(rxq[1]), 32'hEF);
    check("wr_rd_no_cmd_error", 32'(err_pulses - e0), 32'd0);

    wq.delete(); wq.push_back(8'h11);
    do_write(16'h00FF, wq);
    wq.delete(); wq.push_back(8'h22);
    do_write(16'h0000, wq);
    do_read(16'hFFFF, 2);
    check("wrap_byte0", 32'(rxq[0]), 32'h11);
    check("wrap_byte1", 32'(rxq[1]), 32'h22);

    e0 = err_pulses;
    m0 = miso_hi_cycles;
    sel_low();
    shift(8'h05, 8, rx);
    for (int i = 0; i < 3; i++) begin
      shift(8'($urandom), 8, rx);
      check("badcmd_miso_byte", 32'(rx), 32'd0);
    end
    sel_high();
    check("badcmd_error_cycles", 32'(err_pulses - e0), 32'd1);
    check("badcmd_miso_high_cycles", 32'(miso_hi_cycles - m0), 32'd0);
    do_read(16'h0010, 1);
    check("badcmd_then_read", 32'(rxq[0]), 32'hBE);

    sel_low();
    head(8'h02, 16'h0020);
    shift(8'hA5, 8, rx);
    model[8'h20] = 8'hA5;
    shift(8'h3C, 4, rx);
    sel_high();
    do_read(16'h0020, 2);
    check("abort_committed", 32'(rxq[0]), 32'hA5);

    sel_low();
    head(8'h03, 16'h0010);
    shift(8'h00, 8, rx);
    check("rstmid_byte0", 32'(rx), 32'hBE);
    shift(8'h00, 2, rx);
    repeat (4) @(negedge clk);
    check("rstmid_miso_before", 32'(spi_miso), 32'(model[8'h11][5]));
    rst_n = 1'b0;
    #1;
    check("rstmid_miso_async", 32'(spi_miso), 32'd0);
    check("rstmid_busy_async", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_select = 1'b1;
    repeat (6) @(negedge clk);
    do_read(16'h0010, 1);
    check("rstmid_fresh_read", 32'(rxq[0]), 32'hBE);

    half = 2;
    for (int t = 0; t < 6; t++) begin
      a = 16'($urandom_range(0, 65535));
      wq.delete(); wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
      do_write(a, wq);
      do_read(a, 2);
      check("clk4_byte0", 32'(rxq[0]), 32'(wq[0]));
      check("clk4_byte1", 32'(rxq[1]), 32'(wq[1]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
